// File: rtl/reset_seq_pkg.sv
// Shared types and default parameter values for the staged reset-release
// sequencer.
//   state_t      : sequencer FSM states
//   DEF_*        : default values for the sequencer parameters
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_STAGES         = 4;
  localparam int unsigned DEF_HOLD_CYCLES        = 8;
  localparam int unsigned DEF_DELAY_WIDTH        = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT_WIDTH = 16;

endpackage

// File: rtl/reset_release_sequencer_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low clear.
//   clk    : destination clock
//   resetn : asynchronous active-low clear (both flops to 0)
//   d      : asynchronous input
//   q      : synchronized output, 2 cycles of latency
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_release_sequencer.sv
// Staged reset-release controller. Holds every downstream domain reset,
// waits for PLL lock, then releases the domain resets one by one (bit 0
// first) with a programmable gap. Lock loss or a software request
// re-runs the whole sequence.
//   clk          : system clock
//   resetn       : asynchronous active-low reset
//   pll_locked   : PLL lock (asynchronous, synchronized internally)
//   stage_delay  : inter-stage gap minus one, sampled while in HOLD
//   sw_reset_req : software reset request (level, 4-phase handshake)
//   sw_reset_ack : software reset completion acknowledge
//   stage_resetn : active-low domain resets
//   all_released : every stage released
//   lock_timeout : sticky, lock wait exceeded the counter range
module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES         = DEF_NUM_STAGES,
  parameter int unsigned HOLD_CYCLES        = DEF_HOLD_CYCLES,
  parameter int unsigned DELAY_WIDTH        = DEF_DELAY_WIDTH,
  parameter int unsigned LOCK_TIMEOUT_WIDTH = DEF_LOCK_TIMEOUT_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   pll_locked,
  input  logic [DELAY_WIDTH-1:0] stage_delay,
  input  logic                   sw_reset_req,
  output logic                   sw_reset_ack,
  output logic [NUM_STAGES-1:0]  stage_resetn,
  output logic                   all_released,
  output logic                   lock_timeout
);

  localparam int unsigned IDXW  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int unsigned HOLDW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned LCKW  = LOCK_TIMEOUT_WIDTH;

  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NUM_STAGES - 1);
  localparam logic [HOLDW-1:0] LAST_HOLD = HOLDW'(HOLD_CYCLES - 1);
  localparam logic [LCKW-1:0]  LOCK_MAX  = '1;

  logic lock_s;

  state_t                 state, state_d;
  logic [HOLDW-1:0]       hold_cnt, hold_cnt_d;
  logic [LCKW-1:0]        lock_cnt, lock_cnt_d;
  logic [DELAY_WIDTH-1:0] cnt, cnt_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_q_d;
  logic [IDXW-1:0]        idx, idx_d;
  logic [NUM_STAGES-1:0]  stage_resetn_d;
  logic                   all_released_d;
  logic                   sw_reset_ack_d;
  logic                   lock_timeout_d;
  logic                   ack_pending, ack_pending_d;
  logic                   sw_trigger;

  sync_2ff u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_locked),
    .q      (lock_s)
  );

  // A request only counts while the previous handshake has completed.
  assign sw_trigger = sw_reset_req && !sw_reset_ack;

  always_comb begin
    state_d        = state;
    hold_cnt_d     = hold_cnt;
    lock_cnt_d     = lock_cnt;
    cnt_d          = cnt;
    delay_q_d      = delay_q;
    idx_d          = idx;
    stage_resetn_d = stage_resetn;
    all_released_d = all_released;
    sw_reset_ack_d = sw_reset_ack;
    lock_timeout_d = lock_timeout;
    ack_pending_d  = ack_pending;

    // Handshake return-to-zero is independent of the sequencer state.
    if (sw_reset_ack && !sw_reset_req) begin
      sw_reset_ack_d = 1'b0;
    end

    unique case (state)
      HOLD: begin
        stage_resetn_d = '0;
        all_released_d = 1'b0;
        delay_q_d      = stage_delay;
        lock_cnt_d     = '0;
        if (hold_cnt == LAST_HOLD) begin
          hold_cnt_d = '0;
          state_d    = WAIT_LOCK;
        end else begin
          hold_cnt_d = hold_cnt + HOLDW'(1);
        end
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          state_d    = RELEASE;
          idx_d      = '0;
          cnt_d      = '0;
          lock_cnt_d = '0;
        end else begin
          // Flag on the edge the counter becomes all-ones, then saturate.
          if (lock_cnt != LOCK_MAX) begin
            lock_cnt_d = lock_cnt + LCKW'(1);
          end
          if (lock_cnt >= LOCK_MAX - LCKW'(1)) begin
            lock_timeout_d = 1'b1;
          end
        end
      end

      RELEASE: begin
        if (!lock_s) begin
          state_d        = HOLD;
          stage_resetn_d = '0;
          all_released_d = 1'b0;
          idx_d          = '0;
          cnt_d          = '0;
          hold_cnt_d     = '0;
        end else if (cnt == delay_q) begin
          stage_resetn_d[idx] = 1'b1;
          cnt_d               = '0;
          idx_d               = idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            idx_d          = '0;
            all_released_d = 1'b1;
            state_d        = RUN;
            if (ack_pending) begin
              sw_reset_ack_d = 1'b1;
              ack_pending_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt + DELAY_WIDTH'(1);
        end
      end

      RUN: begin
        if (!lock_s || sw_trigger) begin
          state_d        = HOLD;
          stage_resetn_d = '0;
          all_released_d = 1'b0;
          idx_d          = '0;
          cnt_d          = '0;
          hold_cnt_d     = '0;
          if (sw_trigger) begin
            ack_pending_d = 1'b1;
          end
        end
      end

      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= HOLD;
      hold_cnt     <= '0;
      lock_cnt     <= '0;
      cnt          <= '0;
      delay_q      <= '0;
      idx          <= '0;
      stage_resetn <= '0;
      all_released <= 1'b0;
      sw_reset_ack <= 1'b0;
      lock_timeout <= 1'b0;
      ack_pending  <= 1'b0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_cnt_d;
      lock_cnt     <= lock_cnt_d;
      cnt          <= cnt_d;
      delay_q      <= delay_q_d;
      idx          <= idx_d;
      stage_resetn <= stage_resetn_d;
      all_released <= all_released_d;
      sw_reset_ack <= sw_reset_ack_d;
      lock_timeout <= lock_timeout_d;
      ack_pending  <= ack_pending_d;
    end
  end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer. Expected output-change
// events (edge number after reset release + output vector) are queued as
// stimulus is applied; a monitor pops one entry per observed change.
module tb_reset_release_sequencer;

  logic       clk;
  logic       resetn;
  logic       pll_locked;
  logic [7:0] stage_delay;
  logic       sw_reset_req;
  logic       sw_reset_ack;
  logic [3:0] stage_resetn;
  logic       all_released;
  logic       lock_timeout;

  reset_release_sequencer #(
    .NUM_STAGES         (4),
    .HOLD_CYCLES        (8),
    .DELAY_WIDTH        (8),
    .LOCK_TIMEOUT_WIDTH (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pll_locked   (pll_locked),
    .stage_delay  (stage_delay),
    .sw_reset_req (sw_reset_req),
    .sw_reset_ack (sw_reset_ack),
    .stage_resetn (stage_resetn),
    .all_released (all_released),
    .lock_timeout (lock_timeout)
  );

  typedef struct {
    int         rel;
    logic [6:0] val;   // {lock_timeout, sw_reset_ack, all_released, stage_resetn}
  } ev_t;

  ev_t        q[$];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         base  = 0;
  logic       mon_en = 1'b0;
  logic [6:0] prev   = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] outs();
    return {lock_timeout, sw_reset_ack, all_released, stage_resetn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc - base);
    end
  endtask

  task automatic push(input int rel, input logic [3:0] sr, input logic ar,
                      input logic ack, input logic to);
    ev_t e;
    e.rel = rel;
    e.val = {to, ack, ar, sr};
    q.push_back(e);
  endtask

  // Four stage releases starting from RELEASE entry at edge e with gap d+1.
  task automatic push_seq(input int e, input int d, input logic ack_last, input logic to);
    logic [4:0] m;
    for (int i = 0; i < 4; i++) begin
      m = 5'((1 << (i + 1)) - 1);
      push(e + (i + 1) * (d + 1), m[3:0], i == 3, (i == 3) && ack_last, to);
    end
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - base) < n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk(tag, q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 0);
    base   = cyc;
    resetn = 1'b1;
    prev   = outs();
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    logic [6:0] cur;
    ev_t e;
    forever begin
      @(negedge clk);
      cur = outs();
      if (mon_en && cur !== prev) begin
        if (q.size() == 0) begin
          chk("unexpected_change", cur, prev);
        end else begin
          e = q.pop_front();
          chk("event_edge", cyc - base, e.rel);
          chk("event_outs", cur, e.val);
        end
        prev = cur;
      end
    end
  end

  initial begin
    resetn       = 1'b0;
    pll_locked   = 1'b1;
    stage_delay  = 8'd2;
    sw_reset_req = 1'b0;

    // Power-up, gap 3, lock present throughout.
    do_reset();
    push_seq(9, 2, 1'b0, 1'b0);
    drain("s1_drain");

    // Lock pulse low for 5 cycles while in RUN.
    wait_rel(25);
    pll_locked = 1'b0;
    push(28, 4'h0, 1'b0, 1'b0, 1'b0);
    push_seq(37, 2, 1'b0, 1'b0);
    wait_rel(30);
    pll_locked = 1'b1;
    drain("s3_drain");

    // Software request held high through the whole re-sequence.
    wait_rel(55);
    sw_reset_req = 1'b1;
    push(56, 4'h0, 1'b0, 1'b0, 1'b0);
    push_seq(65, 2, 1'b1, 1'b0);
    wait_rel(90);
    chk("s4_ack_held", sw_reset_ack, 1'b1);
    sw_reset_req = 1'b0;
    push(91, 4'hf, 1'b1, 1'b0, 1'b0);
    drain("s4_drain");
    wait_rel(100);
    chk("s4_final", outs(), 7'h1f);

    // No lock: timeout flag after 15 wait cycles, then late lock.
    pll_locked = 1'b0;
    do_reset();
    push(23, 4'h0, 1'b0, 1'b0, 1'b1);
    wait_rel(30);
    chk("s2_still_held", stage_resetn, 4'h0);
    pll_locked = 1'b1;
    push_seq(33, 2, 1'b0, 1'b1);
    drain("s2_drain");

    // Zero gap: one stage per edge.
    stage_delay = 8'd0;
    do_reset();
    push_seq(9, 0, 1'b0, 1'b0);
    drain("s5_drain");

    // Reset mid-sequence after stage 1 release, then clean restart.
    stage_delay = 8'd2;
    do_reset();
    push(12, 4'h1, 1'b0, 1'b0, 1'b0);
    push(15, 4'h3, 1'b0, 1'b0, 1'b0);
    wait_rel(16);
    chk("s6_pre_reset", stage_resetn, 4'h3);
    chk("s6_queue", q.size(), 0);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("s6_async_reset", outs(), 0);
    do_reset();
    push_seq(9, 2, 1'b0, 1'b0);
    drain("s6_drain");
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_release_sequencer.md
# reset_release_sequencer

Staged reset-release controller placed downstream of the board's global reset. It holds all downstream clock-domain resets asserted and waits for PLL lock. It then releases the domain resets one at a time in fixed order, with a programmable gap between stages. It also services a software reset request with a 4-phase handshake and re-runs the sequence on PLL lock loss.

## Interface
- NUM_STAGES, 4, number of sequenced domain resets (>=1)
- HOLD_CYCLES, 8, cycles all stages are held in reset before lock is checked (>=1)
- DELAY_WIDTH, 8, width of stage_delay
- LOCK_TIMEOUT_WIDTH, 16, width of lock-wait counter
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous, active-low
- pll_locked  in  1  PLL lock, asynchronous; synchronized internally with 2 flops
- stage_delay  in  DELAY_WIDTH  inter-stage gap minus one, quasi-static
- sw_reset_req  in  1  software reset request, level, clk domain
- sw_reset_ack  out  1  software reset completion acknowledge
- stage_resetn  out  NUM_STAGES  active-low domain resets; bit 0 released first
- all_released  out  1  high when every stage is released
- lock_timeout  out  1  sticky flag: lock wait exceeded the counter range

## Operation
- Reset values: stage_resetn all 0, all_released 0, sw_reset_ack 0, lock_timeout 0, state HOLD, all counters 0, sync flops 0, ack_pending 0.
- HOLD: all stage_resetn 0 and all_released 0. Counts HOLD_CYCLES cycles, then goes to WAIT_LOCK. delay_q <= stage_delay on every HOLD cycle.
- WAIT_LOCK: the lock-wait counter increments each cycle.
  - When the counter reaches all-ones, lock_timeout <= 1. The flag is cleared only by resetn. Waiting continues; the counter saturates.
  - When lock_s == 1, go to RELEASE with idx=0 and cnt=0. The lock-wait counter clears.
- RELEASE: each cycle:
  - If cnt == delay_q: stage_resetn[idx] <= 1, cnt <= 0, idx <= idx+1.
  - Otherwise cnt <= cnt+1.
  - On the edge that releases idx == NUM_STAGES-1: all_released <= 1 and go to RUN.
- RUN: outputs hold.
- Lock loss: lock_s == 0 in WAIT_LOCK is a normal wait. lock_s == 0 in RELEASE or RUN sends the block to HOLD; all stages reassert on the next edge and idx/cnt clear.
- Software reset, 4-phase handshake:
  - In RUN, sw_reset_req == 1 with sw_reset_ack == 0 sets ack_pending and goes to HOLD.
  - When RUN is next reached with ack_pending set, sw_reset_ack <= 1 on the same edge as all_released, and ack_pending clears.
  - sw_reset_ack stays 1 until sw_reset_req == 0, then drops the next edge.
  - A req still high while ack is high does not retrigger.
  - A req raised outside RUN is ignored until RUN.
- Simultaneous lock loss and sw_reset_req in RUN: go to HOLD and set ack_pending (both honoured).
- Lock loss while ack_pending is set: ack_pending is retained; ack is delivered at the next RUN.
- delay_q = 0 releases one stage per cycle.
- delay_q is all-ones: gap of 2^DELAY_WIDTH cycles; no overflow, because cnt is DELAY_WIDTH bits and compares before incrementing.
- resetn asserted mid-sequence: all outputs return to reset values asynchronously; ack_pending is lost.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- pll_locked to lock_s latency: 2 cycles.
- First edge after resetn deasserts is edge 1. Edges 1..HOLD_CYCLES are HOLD. WAIT_LOCK→RELEASE occurs at the first edge with lock_s == 1.
- Stage 0 releases delay_q+1 edges after RELEASE entry. Stages are spaced delay_q+1 edges apart.
- Lock loss to all stages asserted: 3 edges (2 sync + 1 register).
- sw_reset_req rise (in RUN, ack low) to stage_resetn all 0: 1 edge.

## Structure
- Package reset_seq_pkg holds:
  - the state enum {HOLD, WAIT_LOCK, RELEASE, RUN}
  - default parameter constants
- Sub-module sync_2ff: two-flop synchronizer with async active-low clear. Used for pll_locked.
- idx width is $clog2(NUM_STAGES), minimum 1.

## Test plan
- Power-up, defaults, stage_delay=2, pll_locked=1 throughout -> stage_resetn bits 0..3 rise at edges 12, 15, 18, 21; all_released rises at edge 21; no other output changes.
- pll_locked=0 held, LOCK_TIMEOUT_WIDTH=4 -> lock_timeout rises 15 cycles after WAIT_LOCK entry, stage_resetn stays 0. pll_locked=1 later -> sequence completes and lock_timeout stays 1.
- In RUN, pulse pll_locked low for 5 cycles -> stage_resetn = 0 three edges after the fall, then full re-sequence; sw_reset_ack stays 0.
- In RUN, raise sw_reset_req and hold it -> stage_resetn = 0 next edge, re-sequence, sw_reset_ack=1 on the all_released edge. Drop req -> ack=0 next edge and no retrigger while req was held.
- stage_delay=0 -> the four stages release on four consecutive edges.
- Assert resetn mid-RELEASE (stage 1 released) -> all outputs 0 immediately. Restart matches scenario 1 timing.
